// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Result registered WIDTH edges after start is accepted; start is ignored while busy.
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [WIDTH-1:0] r_sr;
  logic [BW-1:0]   r_acc;
  logic [BW-1:0]   w_adj;
  logic [BW-1:0]   w_acc_shift;
  logic            w_carry;
  logic            w_last;
  logic            r_ovf;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;
  logic [BW-1:0]   r_bcd;
  logic            r_overflow;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_last       = (r_cnt == CW'(1));
    case (r_state)
      IDLE:    if (start)  w_state_next = SHIFT;
      SHIFT:   if (w_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // All digits adjusted from pre-shift values, then one left shift of {acc, sr}.
  always_comb begin
    w_adj = r_acc;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_acc[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_acc[4*k +: 4] + 4'd3;
    end
    w_carry     = w_adj[BW-1];
    w_acc_shift = {w_adj[BW-2:0], r_sr[WIDTH-1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr       <= '0;
      r_acc      <= '0;
      r_ovf      <= 1'b0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bcd      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_busy <= (w_state_next != IDLE);
      r_done <= (w_state_next == DONE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sr  <= bin;
            r_acc <= '0;
            r_ovf <= 1'b0;
            r_cnt <= CW'(WIDTH);
          end
        end
        SHIFT: begin
          r_sr  <= r_sr << 1;
          r_acc <= w_acc_shift;
          r_ovf <= r_ovf | w_carry;
          r_cnt <= r_cnt - CW'(1);
          if (w_last) begin
            r_bcd      <= w_acc_shift;
            r_overflow <= r_ovf | w_carry;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign bcd      = r_bcd;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: table vectors, hand-written handshake/reset sequences,
// exhaustive sweep and random values against a decimal-arithmetic reference.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [7:0]  bin_a = '0, bin_b = '0;
  logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
  logic [11:0] bcd_a;
  logic [7:0]  bcd_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .bin(bin_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a));

  bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .bin(bin_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b));

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] exp_bcd;
    logic        exp_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: decimal digits of v mod 10^digits, packed as BCD.
  function automatic logic [11:0] ref_bcd(input int v, input int digits);
    logic [11:0] r;
    int t;
    r = '0;
    t = v;
    for (int k = 0; k < digits; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input int v, input int digits);
    return v >= 10 ** digits;
  endfunction

  // One full conversion; returns result, edges from accept to done, busy
  // cycle count and done level one cycle after the pulse.
  task automatic conv(input int sel, input logic [7:0] v,
                      output logic [11:0] res, output logic of,
                      output int lat, output int busy_cnt, output logic done_after);
    @(negedge clk);
    if (sel == 0) begin start_a = 1'b1; bin_a = v; end
    else          begin start_b = 1'b1; bin_b = v; end
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    lat = 0;
    busy_cnt = (sel == 0) ? int'(busy_a) : int'(busy_b);
    res = '0;
    of = 1'b0;
    done_after = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      busy_cnt += (sel == 0) ? int'(busy_a) : int'(busy_b);
      if ((sel == 0) ? done_a : done_b) begin
        lat = n;
        res = (sel == 0) ? bcd_a : {4'h0, bcd_b};
        of  = (sel == 0) ? ovf_a : ovf_b;
        break;
      end
    end
    if (lat == 0) chk("conv_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    done_after = (sel == 0) ? done_a : done_b;
    busy_cnt += (sel == 0) ? int'(busy_a) : int'(busy_b);
  endtask

  initial begin
    vec_t vecs[8];
    logic [11:0] res;
    logic        of, da;
    int          lat, bc, ndone, okd;
    logic [7:0]  v;

    vecs[0] = '{8'd0,   12'h000, 1'b0};
    vecs[1] = '{8'd255, 12'h255, 1'b0};
    vecs[2] = '{8'd99,  12'h099, 1'b0};
    vecs[3] = '{8'd128, 12'h128, 1'b0};
    vecs[4] = '{8'd1,   12'h001, 1'b0};
    vecs[5] = '{8'd9,   12'h009, 1'b0};
    vecs[6] = '{8'd10,  12'h010, 1'b0};
    vecs[7] = '{8'd100, 12'h100, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy_a, 0);
    chk("reset_done", done_a, 0);
    chk("reset_bcd", bcd_a, 0);
    chk("reset_ovf", ovf_a, 0);
    @(negedge clk);
    rst = 1'b0;

    // Test 1: zero input, latency, busy span, single done pulse.
    conv(0, 8'd0, res, of, lat, bc, da);
    chk("t1_bcd", res, 12'h000);
    chk("t1_ovf", of, 0);
    chk("t1_latency", lat, 8);
    chk("t1_busy_cycles", bc, 9);
    chk("t1_done_once", da, 0);

    foreach (vecs[i]) begin
      conv(0, vecs[i].bin, res, of, lat, bc, da);
      chk($sformatf("vec%0d_bcd", i), res, vecs[i].exp_bcd);
      chk($sformatf("vec%0d_ovf", i), of, vecs[i].exp_ovf);
      chk($sformatf("vec%0d_lat", i), lat, 8);
    end

    // Test 3: start held high; mid-conversion bin change and busy starts ignored.
    @(negedge clk);
    start_a = 1'b1;
    bin_a = 8'd200;
    ndone = 0;
    for (int e = 0; e <= 22; e++) begin
      @(posedge clk);
      #1;
      if (e == 3) bin_a = 8'd7;
      if (e == 19) start_a = 1'b0;
      if (done_a) begin
        ndone++;
        if (ndone == 1) begin
          chk("t3_first_edge", e, 8);
          chk("t3_first_bcd", bcd_a, 12'h200);
        end else begin
          chk("t3_second_edge", e, 18);
          chk("t3_second_bcd", bcd_a, 12'h007);
        end
      end
    end
    chk("t3_done_count", ndone, 2);
    repeat (2) @(posedge clk);

    // Test 4: reset at edge 4 aborts conversion.
    @(negedge clk);
    start_a = 1'b1;
    bin_a = 8'd173;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_busy", busy_a, 0);
    chk("t4_done", done_a, 0);
    chk("t4_bcd", bcd_a, 0);
    rst = 1'b0;
    ndone = 0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk);
      #1;
      if (done_a) ndone++;
    end
    chk("t4_no_done", ndone, 0);
    conv(0, 8'd173, res, of, lat, bc, da);
    chk("t4_restart_bcd", res, 12'h173);
    chk("t4_restart_lat", lat, 8);

    // Test 5: two-digit instance, truncation and overflow.
    conv(1, 8'd100, res, of, lat, bc, da);
    chk("t5_100_bcd", res, 12'h000);
    chk("t5_100_ovf", of, 1);
    conv(1, 8'd99, res, of, lat, bc, da);
    chk("t5_99_bcd", res, 12'h099);
    chk("t5_99_ovf", of, 0);

    // Test 6: exhaustive sweep, every digit within 0..9.
    for (int x = 0; x < 256; x++) begin
      conv(0, 8'(x), res, of, lat, bc, da);
      chk($sformatf("sweep_%0d", x), res, ref_bcd(x, 3));
      okd = 1;
      for (int k = 0; k < 3; k++) if (res[4*k +: 4] > 4'd9) okd = 0;
      chk($sformatf("sweep_digits_%0d", x), okd, 1);
    end

    // Random values on the two-digit instance.
    for (int r = 0; r < 60; r++) begin
      v = 8'($urandom_range(0, 255));
      conv(1, v, res, of, lat, bc, da);
      chk($sformatf("rand_bcd_%0d", v), res, ref_bcd(int'(v), 2));
      chk($sformatf("rand_ovf_%0d", v), of, ref_ovf(int'(v), 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
